// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's memory bus, instruction handshake,
// jump request and debug pc into one interface.
//   master : fetch unit side (drives mem_addr, mem_ce, instr, instr_valid, pc)
//   slave  : memory / control unit side (drives mem_rdata, fetch_en,
//            instr_ready, jmp_en, jmp_addr)
interface fetch_unit_if;
    logic [15:0] mem_addr;
    logic        mem_ce;
    logic [7:0]  mem_rdata;
    logic        fetch_en;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jmp_en;
    logic [15:0] jmp_addr;
    logic [15:0] pc;

    modport master (
        output mem_addr, mem_ce, instr, instr_valid, pc,
        input  mem_rdata, fetch_en, instr_ready, jmp_en, jmp_addr
    );

    modport slave (
        input  mem_addr, mem_ce, instr, instr_valid, pc,
        output mem_rdata, fetch_en, instr_ready, jmp_en, jmp_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 16-bit instructions as two bytes from an 8-bit memory
// with one cycle of read latency, and holds each instruction for the
// control unit until it is accepted.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (memory bus, instr handshake, jump, pc)
// Parameter RESET_PC: program counter value loaded on reset.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {F_HI, F_LO, F_CAP, VALID} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] mem_addr;
    logic        mem_ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= F_HI;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mem_addr = pc_q;
        mem_ce   = 1'b0;

        case (state_q)
            F_HI: begin
                mem_ce = bus.fetch_en;
                if (bus.fetch_en) state_d = F_LO;
            end
            F_LO: begin
                // Data returned this cycle belongs to the F_HI read of pc.
                mem_addr        = pc_q + 16'd1;
                mem_ce          = 1'b1;
                instr_d[15:8]   = bus.mem_rdata;
                state_d         = F_CAP;
            end
            F_CAP: begin
                instr_d[7:0] = bus.mem_rdata;
                pc_d         = pc_q + 16'd2;
                state_d      = VALID;
            end
            VALID: begin
                if (bus.instr_ready) state_d = F_HI;
            end
            default: state_d = F_HI;
        endcase

        // A jump overrides both the pc increment and any state transition;
        // a partially assembled instr is left behind but never marked valid.
        if (bus.jmp_en) begin
            pc_d    = bus.jmp_addr;
            state_d = F_HI;
        end

        // Reset forces the state to F_HI asynchronously, where mem_ce would
        // otherwise follow fetch_en; gate it so no read leaks out under reset.
        if (rst) mem_ce = 1'b0;
    end

    assign bus.mem_addr    = mem_addr;
    assign bus.mem_ce      = mem_ce;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.pc          = pc_q;

endmodule
